// File: rtl/cordic_stream_feeder.sv
// cordic_stream_feeder
// Buffers a stream of IEEE-754 single arguments in a small FIFO, feeds them
// into an external fixed-latency CORDIC pipeline, tracks which pipeline
// stages hold real arguments with a tag shift register, and presents the
// results on a valid/ready output with full backpressure.
// LATENCY must be at least 2 and FIFO_DEPTH a power of two of at least 2.
module cordic_stream_feeder #(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clock,
  input  logic                            aclr_n,
  input  logic                            in_valid,
  input  logic [31:0]                     in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  output logic [31:0]                     out_data,
  input  logic                            out_ready,
  output logic [31:0]                     ppl_dataa,
  output logic                            ppl_clk_en,
  output logic                            ppl_aclr,
  input  logic [31:0]                     ppl_result,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [LATENCY-1:0] r_vtag;
  logic               r_out_valid;
  logic [31:0]        r_out_data;

  logic w_nonempty;
  logic w_full;
  logic w_stall;
  logic w_clk_en;
  logic w_push;
  logic w_pop;
  logic w_capture;

  // Handshake and pipeline-advance decisions derived from current state.
  always_comb begin
    w_nonempty = (r_count != {CW{1'b0}});
    w_full     = (r_count == CW'(FIFO_DEPTH));
    // The pipeline may only freeze when its last stage holds a result that
    // has nowhere to go; bubbles in the last stage never block it.
    w_stall    = r_vtag[LATENCY-1] && r_out_valid && !out_ready;
    w_clk_en   = !w_stall && (w_nonempty || (r_vtag != {LATENCY{1'b0}}));
    w_push     = in_valid && !w_full;
    w_pop      = w_clk_en && w_nonempty;
    w_capture  = w_clk_en && r_vtag[LATENCY-1];
  end

  assign in_ready   = !w_full;
  assign ppl_clk_en = w_clk_en;
  assign ppl_aclr   = !aclr_n;
  assign ppl_dataa  = w_nonempty ? r_mem[r_rd_ptr] : 32'h0000_0000;
  assign fifo_count = r_count;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign idle       = !w_nonempty && (r_vtag == {LATENCY{1'b0}}) && !r_out_valid;

  // FIFO storage write; contents need no reset because pointers gate reads.
  always_ff @(posedge clock) begin
    if (aclr_n && w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Occupancy tags travel in lockstep with the external pipeline stages.
  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      r_vtag <= {LATENCY{1'b0}};
    end else if (w_clk_en) begin
      r_vtag <= {r_vtag[LATENCY-2:0], w_nonempty};
    end else begin
      r_vtag <= r_vtag;
    end
  end

  // Output holding register: capture wins over handoff so a result can be
  // replaced in the same edge it is consumed, sustaining one per cycle.
  always_ff @(posedge clock) begin
    if (!aclr_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 32'h0000_0000;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_data  <= ppl_result;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_data  <= r_out_data;
    end else begin
      r_out_valid <= r_out_valid;
      r_out_data  <= r_out_data;
    end
  end

endmodule

// File: tb/tb_cordic_stream_feeder.sv
// Self-checking bench for cordic_stream_feeder: a stand-in CORDIC pipeline,
// a scoreboard of expected results in acceptance order, directed scenarios
// and a randomized traffic phase.
module tb_cordic_stream_feeder;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic        clock;
  logic        aclr_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [31:0] ppl_dataa;
  logic        ppl_clk_en;
  logic        ppl_aclr;
  logic [31:0] ppl_result;
  logic [2:0]  fifo_count;
  logic        idle;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] stage[LAT];

  cordic_stream_feeder #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .aclr_n(aclr_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .ppl_dataa(ppl_dataa), .ppl_clk_en(ppl_clk_en),
    .ppl_aclr(ppl_aclr), .ppl_result(ppl_result), .fifo_count(fifo_count),
    .idle(idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Transformation applied by the stand-in pipeline.
  function automatic logic [31:0] cos_mock(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h3C3C_C3C3;
  endfunction

  // Stand-in CORDIC: LAT enabled stages, cleared by ppl_aclr.
  always @(posedge clock) begin
    if (ppl_aclr) begin
      for (int i = 0; i < LAT; i++) stage[i] <= 32'h0;
    end else if (ppl_clk_en) begin
      stage[0] <= ppl_dataa;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end
  assign ppl_result = cos_mock(stage[LAT-1]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: records accepted words and checks every handed-off result.
  always @(negedge clock) begin
    if (!aclr_n) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cos_mock(in_data));
        acc_q.push_back(in_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: actual=%0h required=none", out_data);
        end else begin
          check("result_order", out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    aclr_n = 1'b0;
    step();
    step();
    aclr_n = 1'b1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      done = idle && (exp_q.size() == 0);
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    int highs;
    int rises;
    int lows;
    logic prev;
    logic [31:0] w1;
    logic [31:0] w2;

    aclr_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1;
    step();
    step();
    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_ppl_aclr", 32'(ppl_aclr), 32'd1);
    check("rst_out_data", out_data, 32'h0);
    aclr_n = 1'b1;
    #1;
    check("ppl_aclr_release", 32'(ppl_aclr), 32'd0);

    // Single word latency
    in_valid = 1'b1; in_data = 32'h3F80_0000;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 4) check("lat_not_yet", 32'(out_valid), 32'd0);
      if (k == 5) check("lat_valid", 32'(out_valid), 32'd1);
      if (k == 5) check("lat_not_idle", 32'(idle), 32'd0);
      if (k == 6) check("lat_idle_after", 32'(idle), 32'd1);
    end

    // Streaming 16 words back to back
    highs = 0; rises = 0; lows = 0; prev = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k < 16) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        if (!in_ready) lows++;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (out_valid) highs++;
      if (out_valid && !prev) rises++;
      prev = out_valid;
    end
    check("stream_ready_lows", 32'(lows), 32'd0);
    check("stream_results", 32'(highs), 32'd16);
    check("stream_contiguous", 32'(rises), 32'd1);

    // Bubble: words at edges 0 and 3
    w1 = 32'h4000_0000; w2 = 32'h4040_0000;
    in_valid = 1'b1; in_data = w1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 3) begin in_valid = 1'b1; in_data = w2; end
      step();
      in_valid = 1'b0;
      check($sformatf("bubble_valid_e%0d", k), 32'(out_valid), 32'((k == 5) || (k == 8)));
      if (k == 1 || k == 2) check($sformatf("bubble_dataa_e%0d", k), ppl_dataa, 32'h0);
      if (k == 3) check("bubble_dataa_head", ppl_dataa, w2);
    end
    drain();

    // Mid-operation reset discards everything
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = $urandom;
      step();
    end
    in_valid = 1'b0;
    step();
    aclr_n = 1'b0;
    #1;
    check("midrst_ppl_aclr", 32'(ppl_aclr), 32'd1);
    step();
    aclr_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_fifo_count", 32'(fifo_count), 32'd0);
    check("midrst_idle", 32'(idle), 32'd1);
    highs = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (out_valid) highs++;
    end
    check("midrst_no_stale", 32'(highs), 32'd0);

    // Backpressure fills to capacity
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_data = $urandom;
      step();
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(acc_q.size()), 32'(DEPTH + LAT + 1));
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_clk_en", 32'(ppl_clk_en), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    step();
    check("simul_count_pre", 32'(fifo_count), 32'd2);
    check("simul_head_pre", ppl_dataa, acc_q[acc_q.size() - 2]);
    // Push and pop on the same edge
    in_valid = 1'b1; in_data = $urandom;
    step();
    in_valid = 1'b0;
    check("simul_count_post", 32'(fifo_count), 32'd2);
    check("simul_head_post", ppl_dataa, acc_q[acc_q.size() - 2]);
    drain();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      step();
      check("rand_in_ready", 32'(in_ready), 32'(fifo_count != 3'(DEPTH)));
    end
    drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_stream_feeder.md
CORDIC_STREAM_FEEDER -- requirements
Module: cordic_stream_feeder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, giving enabled clock edges from ppl_dataa capture to valid ppl_result.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the input FIFO depth in 32-bit words (power of two).
REQ-003 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port aclr_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_data  input  32  IEEE-754 single angle argument.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a word.
REQ-008 SHALL have port out_valid  output  1  out_data holds a cosine result.
REQ-009 SHALL have port out_data  output  32  IEEE-754 single result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-011 SHALL have port ppl_dataa  output  32  argument to CORDIC pipeline.
REQ-012 SHALL have port ppl_clk_en  output  1  CORDIC pipeline advance enable.
REQ-013 SHALL have port ppl_aclr  output  1  CORDIC pipeline reset, active-high, equal to !aclr_n (combinational).
REQ-014 SHALL have port ppl_result  input  32  CORDIC pipeline output, valid when tag slot LATENCY-1 set.
REQ-015 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  words in input FIFO.
REQ-016 SHALL have port idle  output  1  FIFO empty, no tags set, out_valid low.

Function
REQ-017 Input FIFO SHALL push on in_valid && in_ready; in_ready = (fifo_count != FIFO_DEPTH); no bypass when full.
REQ-018 Read/write pointers SHALL wrap modulo FIFO_DEPTH; push and pop in same cycle SHALL leave fifo_count unchanged.
REQ-019 Tag shift register vtag[LATENCY-1:0] SHALL mirror pipeline occupancy; vtag[k] set means stage k holds a real argument.
REQ-020 stall = vtag[LATENCY-1] && out_valid && !out_ready.
REQ-021 ppl_clk_en SHALL be !stall && (fifo_count != 0 || vtag != 0); pipeline is not clocked when fully empty.
REQ-022 ppl_dataa SHALL equal FIFO head when fifo_count != 0, else 32'h00000000 (bubble).
REQ-023 On an edge with ppl_clk_en high: vtag shifts up one slot, vtag[0] <= (fifo_count != 0), FIFO pops if non-empty.
REQ-024 On an edge with ppl_clk_en high and vtag[LATENCY-1] set: out_data <= ppl_result, out_valid <= 1.
REQ-025 On an edge with out_valid && out_ready and no capture per REQ-024: out_valid <= 0, out_data held.
REQ-026 Capture and handoff in same edge SHALL replace out_data with out_valid staying 1 (full throughput, one result per cycle).
REQ-027 While stall is high, FIFO pops, vtag, out_data and out_valid SHALL hold; FIFO push still allowed if not full.
REQ-028 Latency: word accepted at edge t into idle block SHALL show out_valid high after edge t+LATENCY+1 (5 at default).
REQ-029 Results SHALL leave in acceptance order; no word dropped or duplicated; capacity FIFO_DEPTH+LATENCY+1 words.
REQ-030 idle SHALL be combinational from current state.

Reset
REQ-031 On edge with aclr_n low: FIFO pointers, fifo_count, vtag, out_valid cleared to 0; out_data cleared to 32'h0.
REQ-032 Reset mid-operation SHALL discard all queued and in-flight words; ppl_aclr high in the same cycle so pipeline registers clear.
REQ-033 During reset in_ready SHALL be 1 only after the first edge with aclr_n high is not required; in_ready reads 1 whenever fifo_count = 0, pushes on reset edges are ignored.

Verification
REQ-034 Single word: push 32'h3F800000 at edge 0, out_ready=1 -> out_valid rises after edge 5, out_data = ppl_result sampled at edge 5, idle high after edge 6.
REQ-035 Streaming: 16 words on consecutive edges, out_ready=1 -> 16 results on consecutive cycles, in order, in_ready never low.
REQ-036 Backpressure: out_ready=0, in_valid held high -> exactly 9 words accepted, then in_ready=0, ppl_clk_en=0; raise out_ready -> 9 results in order, no loss.
REQ-037 Bubble: push words at edges 0 and 3 only -> results after edges 5 and 8, out_valid low between, ppl_dataa = 0 on bubble edges.
REQ-038 Mid-op reset: 3 words in flight, aclr_n low one cycle -> next cycle out_valid=0, fifo_count=0, vtag=0, idle=1; no stale result ever appears.
REQ-039 Simultaneous: fifo_count=2 with push and pop on same edge -> fifo_count stays 2, head advances one word.
